clken_gen: RTL and testbench
============================

# clken_gen

Parametrised multi-channel clock-enable generator running in the PLL output domain (CLKOP, 200 MHz in the DSP build). It holds all outputs quiet until the PLL lock indication has been stable for a programmable settle time. It then produces NCH independent single-cycle enable strobes, each with a run-time divide ratio, phase offset and mask, so DSP logic runs from one clock instead of extra PLL outputs. A SYNC input realigns all channels to their programmed phases.

## Interface
- NCH, 4, number of enable channels (1..16)
- DW, 8, width of each DIV/PHASE field
- LOCK_DELAY, 200, CLKI cycles synchronised LOCK must stay high before READY (>=1)

- CLKI  in  1  clock (PLL CLKOP domain)
- RST  in  1  reset, asynchronous, active-high; deassertion synchronous to CLKI (external)
- LOCK  in  1  PLL lock, asynchronous to CLKI
- SYNC  in  1  realign all channel counters (RUN only)
- EN  in  NCH  per-channel CE mask
- DIV  in  NCH*DW  channel i divide field DIV[i*DW +: DW]; period = DIV+1 cycles
- PHASE  in  NCH*DW  channel i phase field PHASE[i*DW +: DW]
- CE  out  NCH  enable strobes, registered
- READY  out  1  high in RUN, registered

## Operation
- LOCK passes a 2-flop synchroniser -> lock_s; both flops reset to 0.
- FSM states: WAIT_LOCK (reset), SETTLE, RUN.
  - WAIT_LOCK: lock_s=1 -> SETTLE, settle counter := 0.
  - SETTLE: lock_s=0 -> WAIT_LOCK. Else if counter == LOCK_DELAY-1 -> RUN, else counter+1.
  - RUN: lock_s=0 -> WAIT_LOCK.
- Settle counter width: clog2(LOCK_DELAY)+1.
- READY registered: 1 exactly while state is RUN.
- Per channel i: down-counter cnt[i] (DW bits) and DIV shadow.
- Load event: transition into RUN, or SYNC=1 while in RUN.
  - cnt[i] := min(PHASE[i], DIV[i]).
  - All CE bits 0 on that edge.
- In RUN, no load event:
  - cnt[i]==0 -> cnt[i] := DIV[i] as sampled on that edge, CE[i] := EN[i].
  - Else cnt[i]-1, CE[i] := 0.
- DIV change takes effect at the next wrap or load; the period in progress completes unchanged.
- EN[i]=0 masks CE[i] only. The counter keeps running, so re-enabling preserves phase.
- DIV=0 gives CE high every cycle.
- PHASE > DIV is clamped to DIV.
- Outside RUN: CE=0, counters held, SYNC ignored.
- Leaving RUN (lock loss): READY and CE go 0 on the same edge as the state change.
- Reset values: all CE=0, READY=0, state WAIT_LOCK, all counters 0, synchroniser 0.
- RST mid-operation: immediate asynchronous clear to the values above. A full LOCK_DELAY settle is required again.

## Timing
- Let edge k be the first edge at which LOCK is sampled high. lock_s is high after edge k+1, and SETTLE is entered at edge k+2.
- READY rises at edge k+LOCK_DELAY+2, which is RUN cycle 0.
- First CE[i]: RUN cycle min(PHASE,DIV)+1. Subsequent CE[i] every DIV+1 cycles.
- LOCK falling, first sampled low at edge j: READY=0 and CE=0 after edge j+2.
- SYNC sampled at edge s in RUN: no CE at s. Next CE[i] at s+min(PHASE,DIV)+1.
- SYNC coincident with a wrap: SYNC wins and the strobe is suppressed.
- SYNC coincident with lock loss: lock loss wins.

## Test plan
- Reset/lock: RST pulse, then LOCK high sampled at edge 10, LOCK_DELAY=200 -> READY rises at edge 212. CE=0 throughout; RST asserted at edge 100 -> settle restarts.
- Divide: DIV0=3,PHASE0=0 -> CE0 in RUN cycles 1,5,9,13. DIV1=0 -> CE1 every cycle from cycle 1. EN3=0 -> CE3 never high.
- Phase and clamp: DIV2=4,PHASE2=2 -> CE2 at cycles 3,8,13. PHASE2=9 with DIV2=4 -> first CE2 at cycle 5.
- Lock loss: LOCK low one cycle during SETTLE at count 150 -> back to WAIT_LOCK and a full 200-cycle recount. LOCK low sampled at edge j in RUN -> READY and CE 0 after edge j+2.
- SYNC: DIV0=3,PHASE0=1, SYNC at an edge where CE0 would wrap -> no CE0 that edge, next CE0 two cycles later, then every 4 cycles.
- DIV change: DIV0=3, CE0 at cycle 5, DIV0 set to 1 at cycle 6 -> CE0 at 9, then 11, 13.

Source files
------------

// File: rtl/clken_gen_if.sv
// Control/strobe bundle for clken_gen: PLL lock, realign request, per-channel
// divide/phase/mask fields in, enable strobes and READY out.
interface clken_gen_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  logic              lock;
  logic              sync;
  logic [NCH-1:0]    en;
  logic [NCH*DW-1:0] div;
  logic [NCH*DW-1:0] phase;
  logic [NCH-1:0]    ce;
  logic              ready;

  modport master (output lock, sync, en, div, phase, input  ce, ready);
  modport slave  (input  lock, sync, en, div, phase, output ce, ready);
endinterface

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator: waits for a settled PLL lock, then emits
// per-channel single-cycle strobes with programmable divide, phase and mask.
module clken_gen #(
  parameter int NCH        = 4,
  parameter int DW         = 8,
  parameter int LOCK_DELAY = 200
) (
  input  logic      clki,
  input  logic      rst,
  clken_gen_if.slave bus
);

  localparam int SW = $clog2(LOCK_DELAY) + 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           lock_m, lock_s;
  logic [SW-1:0]  settle_cnt, settle_cnt_nxt;
  logic           load;
  logic           run_hold;
  logic [DW-1:0]  cnt     [NCH];
  logic [DW-1:0]  div_f   [NCH];
  logic [DW-1:0]  start_f [NCH];
  logic [NCH-1:0] ce_q;
  logic           ready_q;

  // LOCK comes from the PLL analogue side, so it is retimed before any use.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      // NOTE: non-blocking so lock_s takes the previous lock_m, forming two real stages.
      lock_m <= bus.lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      ready_q    <= (state_nxt == RUN);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    load           = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = '0;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (settle_cnt == SW'(LOCK_DELAY - 1)) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          settle_cnt_nxt = settle_cnt + SW'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
        else         load      = bus.sync;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Counters only advance while RUN persists; lock loss freezes them and kills CE.
  assign run_hold = (state == RUN) && (state_nxt == RUN);

  for (genvar g = 0; g < NCH; g++) begin : g_field
    assign div_f[g]   = bus.div[g*DW +: DW];
    assign start_f[g] = (bus.phase[g*DW +: DW] > div_f[g]) ? div_f[g]
                                                           : bus.phase[g*DW +: DW];
  end

  // The down-counter reloads from the live DIV only at wrap or load, so it also
  // acts as the period shadow: a DIV change never disturbs a period in progress.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      // NOTE: counter array is cleared on reset like any other state; it is not a RAM.
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ce_q <= '0;
    end else begin
      ce_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (load) begin
          cnt[i] <= start_f[i];
        end else if (run_hold) begin
          if (cnt[i] == '0) begin
            cnt[i]  <= div_f[i];
            ce_q[i] <= bus.en[i];
          end else begin
            cnt[i] <= cnt[i] - DW'(1);
          end
        end
      end
    end
  end

  assign bus.ce    = ce_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: directed lock/divide/phase/sync scenarios
// followed by randomized traffic against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_clken_gen;

  localparam int NCH        = 4;
  localparam int DW         = 8;
  localparam int LOCK_DELAY = 200;

  logic clki = 1'b0;
  logic rst  = 1'b1;

  always #5 clki = ~clki;

  clken_gen_if #(.NCH(NCH), .DW(DW)) bus ();

  clken_gen #(.NCH(NCH), .DW(DW), .LOCK_DELAY(LOCK_DELAY)) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: lock history, count of consecutive settled edges,
  // and the absolute edge number at which each channel fires next.
  int             edge_n  = 0;
  int             run_cyc = 0;
  bit             l1, l2;
  int             streak;
  bit             ready_m;
  logic [NCH-1:0] ce_m;
  int             next_fire [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    bit            v, was_run, now_run;
    logic [DW-1:0] d, p;
    edge_n++;
    if (rst) begin
      l1 = 0; l2 = 0; streak = 0; ready_m = 0; ce_m = '0;
      return;
    end
    // The FSM sees LOCK as it was sampled two edges earlier.
    v  = l2;
    l2 = l1;
    l1 = bus.lock;
    was_run = ready_m;
    streak  = v ? ((streak > LOCK_DELAY) ? streak : streak + 1) : 0;
    now_run = (streak >= LOCK_DELAY + 1);
    ce_m = '0;
    for (int i = 0; i < NCH; i++) begin
      d = bus.div[i*DW +: DW];
      p = bus.phase[i*DW +: DW];
      if (now_run && (!was_run || bus.sync)) begin
        next_fire[i] = edge_n + ((p > d) ? int'(d) : int'(p)) + 1;
      end else if (now_run && edge_n == next_fire[i]) begin
        ce_m[i]      = bus.en[i];
        next_fire[i] = edge_n + int'(d) + 1;
      end
    end
    run_cyc = (now_run && !was_run) ? 0 : run_cyc + 1;
    ready_m = now_run;
  endtask

  task automatic step();
    @(posedge clki);
    model_edge();
    @(negedge clki);
    check("ready", bus.ready, ready_m);
    check("ce", bus.ce, ce_m);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    check("rst_async_ready", bus.ready, 0);
    check("rst_async_ce", bus.ce, 0);
    step();
    rst = 1'b0;
  endtask

  // k is the first edge that samples LOCK high; READY must rise LOCK_DELAY+2 later.
  task automatic wait_ready(input int k, input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < LOCK_DELAY + 20) begin
      step();
      n++;
    end
    check(tag, edge_n - k, LOCK_DELAY + 2);
  endtask

  function automatic logic [DW-1:0] rnd_field();
    return ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255))
                                       : DW'($urandom_range(0, 6));
  endfunction

  initial begin
    int k;
    bus.lock  = 1'b0;
    bus.sync  = 1'b0;
    bus.en    = 4'b0111;
    bus.div   = {8'd5, 8'd4, 8'd0, 8'd3};
    bus.phase = {8'd1, 8'd2, 8'd0, 8'd0};

    // Reset state, then a settle interrupted by RST and by a one-cycle lock drop.
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();
    bus.lock = 1'b1;
    while (edge_n < 99) step();
    pulse_rst();
    k = edge_n + 1;
    while (edge_n < k + 150) step();
    bus.lock = 1'b0;
    step();
    bus.lock = 1'b1;
    k = edge_n + 1;
    wait_ready(k, "ready_latency");

    // Divide, DIV=0, phase offset and mask from RUN cycle 0.
    for (int c = 1; c <= 16; c++) begin
      step();
      check("ce0_div3",   bus.ce[0], (c % 4) == 1);
      check("ce1_div0",   bus.ce[1], 1);
      check("ce2_phase2", bus.ce[2], (c >= 3) && ((c - 3) % 5 == 0));
      check("ce3_masked", bus.ce[3], 0);
    end

    // SYNC on the CE0 wrap edge (cycle 17), then DIV0 3->1 after the CE at 23.
    bus.phase[7:0] = 8'd1;
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("sync_suppress", bus.ce[0], 0);
    for (int c = 18; c <= 31; c++) begin
      step();
      check("ce0_sync_div", bus.ce[0], (c == 19 || c == 23 || c == 27 || c == 29 || c == 31));
      if (c == 23) bus.div[7:0] = 8'd1;
    end

    // PHASE above DIV clamps: SYNC at cycle 32 -> first CE2 at 37.
    bus.div[23:16]   = 8'd4;
    bus.phase[23:16] = 8'd9;
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    for (int c = 33; c <= 37; c++) begin
      step();
      check("ce2_clamp", bus.ce[2], c == 37);
    end

    // Lock loss in RUN: outputs still live after j and j+1, quiet after j+2.
    bus.lock = 1'b0;
    step();
    check("lockloss_j", bus.ready, 1);
    step();
    check("lockloss_j1", bus.ready, 1);
    step();
    check("lockloss_j2_ready", bus.ready, 0);
    check("lockloss_j2_ce", bus.ce, 0);

    // Randomized traffic: config churn, SYNC, lock glitches and resets.
    for (int seg = 0; seg < 4; seg++) begin
      if (seg % 2 == 1) pulse_rst();
      for (int i = 0; i < NCH; i++) begin
        bus.div[i*DW +: DW]   = rnd_field();
        bus.phase[i*DW +: DW] = rnd_field();
      end
      bus.en   = NCH'($urandom);
      bus.lock = 1'b1;
      k = edge_n + 1;
      wait_ready(k, "ready_latency_rnd");
      for (int c = 0; c < 400; c++) begin
        step();
        bus.sync = ($urandom_range(0, 15) == 0);
        bus.lock = ($urandom_range(0, 299) != 0);
        for (int i = 0; i < NCH; i++) begin
          if ($urandom_range(0, 7) == 0) bus.div[i*DW +: DW]   = rnd_field();
          if ($urandom_range(0, 7) == 0) bus.phase[i*DW +: DW] = rnd_field();
          if ($urandom_range(0, 15) == 0) bus.en[i] = ~bus.en[i];
        end
      end
      bus.sync = 1'b0;
      bus.lock = 1'b0;
      repeat (5) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
